// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter and related schedulers.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after `last`,
// wrapping modulo N, with `last` itself scanned at the very end.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         onehot
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Scan from the far end so the candidate closest to last+1 is written last and wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = N; k >= 1; k--) begin
      cand_s = IW'((int'(last) + k) % N);
      hit_s  = req[cand_s];
      found  = found | hit_s;
      idx    = hit_s ? cand_s : idx;
      onehot = hit_s ? ({{(N-1){1'b0}}, 1'b1} << cand_s) : onehot;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready streams,
// holding each grant for up to BURST accepted beats with zero-bubble handover.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                      clk,
  input  logic                      rstz,
  input  logic                      clear,
  input  logic [N-1:0][WIDTH-1:0]   req_din,
  input  logic [N-1:0]              req_vld,
  output logic [N-1:0]              req_rdy,
  output logic [WIDTH-1:0]          fifo_din,
  output logic                      fifo_din_vld,
  input  logic                      fifo_din_rdy,
  output logic [N-1:0]              grant,
  output logic                      busy
);

  localparam int IW = $clog2(N);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(N - 1);

  arb_state_e       state_r;
  logic [N-1:0]     grant_r;
  logic [IW-1:0]    last_r;
  logic [BW-1:0]    beats_r;

  logic             pick_found_s;
  logic [IW-1:0]    pick_idx_s;
  logic [N-1:0]     pick_onehot_s;
  logic [WIDTH-1:0] din_mux_s;
  logic             accept_s;
  logic             release_s;

  rr_pick #(.N(N)) u_pick (
    .req    (req_vld),
    .last   (last_r),
    .found  (pick_found_s),
    .idx    (pick_idx_s),
    .onehot (pick_onehot_s)
  );

  // AND-OR data mux keyed by the one-hot grant; yields zero while idle.
  always_comb begin
    din_mux_s = '0;
    for (int i = 0; i < N; i++) begin
      din_mux_s = din_mux_s | (req_din[IW'(i)] & {WIDTH{grant_r[IW'(i)]}});
    end
  end

  assign fifo_din     = din_mux_s;
  assign fifo_din_vld = |(req_vld & grant_r);
  assign req_rdy      = grant_r & {N{fifo_din_rdy}};
  assign grant        = grant_r;
  assign busy         = (state_r == GRANT);

  // A dropped valid releases too, which keeps the owner out of the re-pick.
  assign accept_s  = fifo_din_vld & fifo_din_rdy;
  assign release_s = (accept_s && (beats_r == BEAT_LAST)) || !fifo_din_vld;

  // Grant ownership, round-robin pointer and per-grant beat count.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_r <= IDLE;
      grant_r <= '0;
      last_r  <= LAST_RST;
      beats_r <= '0;
    end else if (clear) begin
      state_r <= IDLE;
      grant_r <= '0;
      last_r  <= LAST_RST;
      beats_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            state_r <= GRANT;
            grant_r <= pick_onehot_s;
            last_r  <= pick_idx_s;
            beats_r <= '0;
          end else begin
            grant_r <= '0;
            beats_r <= '0;
          end
        end
        GRANT: begin
          if (release_s && pick_found_s) begin
            grant_r <= pick_onehot_s;
            last_r  <= pick_idx_s;
            beats_r <= '0;
          end else if (release_s) begin
            state_r <= IDLE;
            grant_r <= '0;
            beats_r <= '0;
          end else if (accept_s) begin
            beats_r <= beats_r + BW'(1);
          end else begin
            beats_r <= beats_r;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
          last_r  <= LAST_RST;
          beats_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a behavioural
// owner/pointer/beat-count model plus a FIFO-side write log.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 3;

  logic                    clk = 1'b0;
  logic                    rstz;
  logic                    clear;
  logic [N-1:0][WIDTH-1:0] req_din;
  logic [N-1:0]            req_vld;
  logic [N-1:0]            req_rdy;
  logic [WIDTH-1:0]        fifo_din;
  logic                    fifo_din_vld;
  logic                    fifo_din_rdy;
  logic [N-1:0]            grant;
  logic                    busy;
  logic                    full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // FIFO model: accepts whenever offered and not full.
  assign fifo_din_rdy = fifo_din_vld & ~full;

  fifo_wr_arbiter #(.N(N), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk          (clk),
    .rstz         (rstz),
    .clear        (clear),
    .req_din      (req_din),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .fifo_din     (fifo_din),
    .fifo_din_vld (fifo_din_vld),
    .fifo_din_rdy (fifo_din_rdy),
    .grant        (grant),
    .busy         (busy)
  );

  int               m_owner;
  int               m_last;
  int               m_count;
  int               seq [N];
  logic [WIDTH-1:0] base [N];
  int               wait_beats [N];
  int               last_wr [N];
  bit               order_on;
  int               cyc = 0;
  logic [WIDTH-1:0] wr_q [$];
  int               wr_t [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic bit_at(input logic [N-1:0] v, input int i);
    return (i >= 0) ? v[i[1:0]] : 1'b0;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (v[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_count = 0;
    for (int i = 0; i < N; i++) wait_beats[i] = 0;
  endtask

  // One clock: drive at negedge, check outputs, advance model, return at next negedge.
  task automatic cycle(input logic [N-1:0] v, input logic f, input logic clr);
    logic [N-1:0] eg;
    logic         acc;
    logic [1:0]   r;
    int           p;
    req_vld = v;
    full    = f;
    clear   = clr;
    for (int i = 0; i < N; i++) req_din[i[1:0]] = base[i] | WIDTH'(seq[i] % 64);
    #1;
    eg  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    acc = bit_at(v, m_owner) && !f;
    check_eq("grant", 32'(grant), 32'(eg));
    check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    check_eq("fifo_din_vld", 32'(fifo_din_vld), 32'(bit_at(v, m_owner)));
    check_eq("fifo_din", 32'(fifo_din), (m_owner >= 0) ? 32'(req_din[m_owner[1:0]]) : 32'h0);
    check_eq("req_rdy", 32'(req_rdy), acc ? 32'(eg) : 32'h0);
    check_eq("onehot0", 32'($onehot0(grant)), 32'h1);
    if (fifo_din_vld && fifo_din_rdy) begin
      wr_q.push_back(fifo_din);
      wr_t.push_back(cyc);
      if (order_on) begin
        r = fifo_din[7:6];
        check_eq("order", 32'(fifo_din[5:0]), 32'((last_wr[r] + 1) % 64));
        last_wr[r] = int'(fifo_din[5:0]);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!v[j[1:0]] || j == m_owner) begin
        wait_beats[j] = 0;
      end else if (acc) begin
        wait_beats[j]++;
        check_eq("starve", 32'(wait_beats[j] <= 3 * BURST), 32'h1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_vld[i[1:0]] && req_rdy[i[1:0]]) seq[i]++;
    end
    if (clr) begin
      model_reset();
    end else if (m_owner < 0) begin
      p = pick(v, m_last);
      if (p >= 0) begin
        m_owner = p;
        m_last  = p;
        m_count = 0;
      end
    end else if ((acc && m_count + 1 == BURST) || !bit_at(v, m_owner)) begin
      p       = pick(v, m_last);
      m_owner = p;
      if (p >= 0) m_last = p;
      m_count = 0;
    end else if (acc) begin
      m_count++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2;
    rstz = 1'b0;
    #1;
    check_eq("arst_grant", 32'(grant), 32'h0);
    check_eq("arst_busy", 32'(busy), 32'h0);
    check_eq("arst_vld", 32'(fifo_din_vld), 32'h0);
    check_eq("arst_rdy", 32'(req_rdy), 32'h0);
    model_reset();
    @(negedge clk);
    rstz = 1'b1;
  endtask

  task automatic restart_streams();
    for (int i = 0; i < N; i++) begin
      seq[i]     = 0;
      base[i]    = WIDTH'(i << 6);
      last_wr[i] = 63;
    end
    wr_q.delete();
    wr_t.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rv;
    logic [N-1:0] g_hold;
    rstz     = 1'b0;
    clear    = 1'b0;
    full     = 1'b0;
    req_vld  = '0;
    req_din  = '0;
    order_on = 1'b0;
    model_reset();
    restart_streams();
    repeat (3) @(negedge clk);
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_din", 32'(fifo_din), 32'h0);
    rstz = 1'b1;
    cycle(4'b0000, 1'b0, 1'b0);

    // Single requester 2 streams A0..A5: bursts of BURST, re-grant without a bubble.
    restart_streams();
    base[2] = 8'hA0;
    cycle(4'b0100, 1'b0, 1'b0);
    check_eq("t1_grant", 32'(grant), 32'h4);
    for (int k = 0; k < 20 && seq[2] < 6; k++) cycle((seq[2] < 6) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
    check_eq("t1_count", 32'(seq[2]), 32'd6);
    cycle(4'b0000, 1'b0, 1'b0);
    check_eq("t1_idle", 32'(grant), 32'h0);
    check_eq("t1_nwr", 32'(wr_q.size()), 32'd6);
    for (int k = 0; k < wr_q.size(); k++) begin
      check_eq("t1_data", 32'(wr_q[k]), 32'(8'hA0 + k));
      check_eq("t1_nobubble", 32'(wr_t[k]), 32'(wr_t[0] + k));
    end

    // All four continuously valid after reset: 0,1,2,3,0,... each for BURST beats.
    async_reset();
    restart_streams();
    for (int k = 0; k < 8 * BURST + 1; k++) cycle(4'b1111, 1'b0, 1'b0);
    check_eq("t2_nwr", 32'(wr_q.size()), 32'(8 * BURST));
    for (int k = 0; k < wr_q.size(); k++) begin
      check_eq("t2_owner", 32'(wr_q[k][7:6]), 32'((k / BURST) % N));
      check_eq("t2_nobubble", 32'(wr_t[k]), 32'(wr_t[0] + k));
    end

    // FIFO full for 5 cycles after the first beat; burst then finishes its count.
    async_reset();
    restart_streams();
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    g_hold = grant;
    repeat (5) cycle(4'b0001, 1'b1, 1'b0);
    check_eq("t3_held", 32'(grant), 32'(g_hold));
    check_eq("t3_frozen", 32'(wr_q.size()), 32'd1);
    repeat (BURST - 1) cycle(4'b0001, 1'b0, 1'b0);
    check_eq("t3_done", 32'(wr_q.size()), 32'(BURST));

    // Owner 1 drops after one beat while 0 and 3 wait: pointer favours 3.
    async_reset();
    restart_streams();
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b1001, 1'b0, 1'b0);
    check_eq("t4_handover", 32'(grant), 32'h8);
    cycle(4'b0000, 1'b0, 1'b0);

    // Async reset and synchronous clear mid-burst; requester 0 wins afterwards.
    restart_streams();
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    async_reset();
    cycle(4'b1111, 1'b0, 1'b0);
    check_eq("t5_rst_win", 32'(grant), 32'h1);
    wr_q.delete();
    cycle(4'b1111, 1'b0, 1'b1);
    check_eq("t5_clr_drop", 32'(grant), 32'h0);
    check_eq("t5_clr_beat", 32'(wr_q.size()), 32'd1);
    cycle(4'b1111, 1'b0, 1'b0);
    check_eq("t5_clr_win", 32'(grant), 32'h1);

    // Random traffic, FIFO back-pressure and rare clears.
    async_reset();
    restart_streams();
    order_on = 1'b1;
    rv = '0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (rv[i[1:0]]) rv[i[1:0]] = ($urandom_range(0, 7) != 0);
        else            rv[i[1:0]] = ($urandom_range(0, 2) == 0);
      end
      cycle(rv, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
